// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller and its BCD counters.
package stopwatch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_e;

  localparam int DIGIT_W      = 4;
  localparam int SEC_TENS_MAX = 5;
  localparam int UNITS_MAX    = 9;

  typedef struct packed {
    logic [DIGIT_W-1:0] min_tens;
    logic [DIGIT_W-1:0] min_ones;
    logic [DIGIT_W-1:0] sec_tens;
    logic [DIGIT_W-1:0] sec_ones;
  } mmss_t;
endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Command pulses in, BCD display and status out.
interface stopwatch_ctrl_if;
  import stopwatch_pkg::*;

  logic               start_stop;
  logic               lap;
  logic               clear;
  logic [DIGIT_W-1:0] sec_ones;
  logic [DIGIT_W-1:0] sec_tens;
  logic [DIGIT_W-1:0] min_ones;
  logic [DIGIT_W-1:0] min_tens;
  logic               running;
  logic               lap_valid;
  logic               overflow;

  modport master (
    output start_stop, lap, clear,
    input  sec_ones, sec_tens, min_ones, min_tens, running, lap_valid, overflow
  );

  modport slave (
    input  start_stop, lap, clear,
    output sec_ones, sec_tens, min_ones, min_tens, running, lap_valid, overflow
  );
endinterface

// File: rtl/stopwatch_ctrl_bcd_mod60.sv
// Two-digit BCD counter 00..59 with a combinational carry out on the wrap.
module bcd_mod60
  import stopwatch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [DIGIT_W-1:0] ones,
  output logic [DIGIT_W-1:0] tens,
  output logic               carry
);
  logic [DIGIT_W-1:0] ones_q, ones_d;
  logic [DIGIT_W-1:0] tens_q, tens_d;
  logic               ones_wrap, tens_wrap;

  assign ones_wrap = (ones_q == DIGIT_W'(UNITS_MAX));
  assign tens_wrap = (tens_q == DIGIT_W'(SEC_TENS_MAX));

  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    if (en) begin
      if (ones_wrap) begin
        ones_d = '0;
        tens_d = tens_wrap ? '0 : tens_q + 1'b1;
      end else begin
        ones_d = ones_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ones_q <= '0;
      tens_q <= '0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
    end
  end

  assign ones  = ones_q;
  assign tens  = tens_q;
  assign carry = en && ones_wrap && tens_wrap;
endmodule

// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch: command FSM, prescaler, lap latch, sticky overflow and display mux.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  stopwatch_ctrl_if.slave  sw
);
  localparam int PS_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  state_e          state_q, state_d;
  logic [PS_W-1:0] presc_q, presc_d;
  mmss_t           lap_q, lap_d;
  logic            ovf_q, ovf_d;
  mmss_t           live, disp;
  logic            cmd_clr, cmd_ss, cmd_lap;
  logic            active, tick, sec_carry, min_carry, cnt_rst;

  // Priority clear > start_stop > lap; losers in the same cycle are dropped.
  assign cmd_clr = sw.clear;
  assign cmd_ss  = sw.start_stop && !sw.clear;
  assign cmd_lap = sw.lap && !sw.start_stop && !sw.clear;

  assign active = (state_q == RUN) || (state_q == LAP);
  assign tick   = active && (presc_q == PS_W'(PRESCALE - 1));

  always_comb begin
    state_d = state_q;
    if (cmd_clr) begin
      state_d = IDLE;
    end else if (cmd_ss) begin
      unique case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        LAP:     state_d = PAUSE;
        default: state_d = IDLE;
      endcase
    end else if (cmd_lap) begin
      if (state_q == RUN)      state_d = LAP;
      else if (state_q == LAP) state_d = RUN;
    end
  end

  always_comb begin
    presc_d = presc_q;
    lap_d   = lap_q;
    ovf_d   = ovf_q;
    if (cmd_clr || state_q == IDLE) presc_d = '0;
    else if (active)                presc_d = tick ? '0 : presc_q + 1'b1;
    if (cmd_clr)                            lap_d = '0;
    else if (state_q == RUN && cmd_lap)     lap_d = live;
    if (cmd_clr)        ovf_d = 1'b0;
    else if (min_carry) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      presc_q <= '0;
      lap_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      lap_q   <= lap_d;
      ovf_q   <= ovf_d;
    end
  end

  // Clear zeroes the digit counters through their synchronous reset.
  assign cnt_rst = rst && !sw.clear;

  bcd_mod60 u_sec (
    .clk   (clk),
    .rst   (cnt_rst),
    .en    (tick),
    .ones  (live.sec_ones),
    .tens  (live.sec_tens),
    .carry (sec_carry)
  );

  bcd_mod60 u_min (
    .clk   (clk),
    .rst   (cnt_rst),
    .en    (sec_carry),
    .ones  (live.min_ones),
    .tens  (live.min_tens),
    .carry (min_carry)
  );

  assign disp         = (state_q == LAP) ? lap_q : live;
  assign sw.sec_ones  = disp.sec_ones;
  assign sw.sec_tens  = disp.sec_tens;
  assign sw.min_ones  = disp.min_ones;
  assign sw.min_tens  = disp.min_tens;
  assign sw.running   = active;
  assign sw.lap_valid = (state_q == LAP);
  assign sw.overflow  = ovf_q;
endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter PRESCALE, default 4: clk cycles per one count increment; legal range is 2 or more.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-low.
REQ-004 start_stop  input  1  one-cycle command pulse: start, pause or resume.
REQ-005 lap  input  1  one-cycle command pulse: freeze or unfreeze the display.
REQ-006 clear  input  1  one-cycle command pulse: return to zero and IDLE.
REQ-007 sec_ones  output  4  displayed seconds units, BCD 0-9.
REQ-008 sec_tens  output  4  displayed seconds tens, BCD 0-5.
REQ-009 min_ones  output  4  displayed minutes units, BCD 0-9.
REQ-010 min_tens  output  4  displayed minutes tens, BCD 0-5.
REQ-011 running  output  1  high in RUN or LAP.
REQ-012 lap_valid  output  1  high in LAP, meaning the display shows the latched lap value.
REQ-013 overflow  output  1  sticky flag, set when the count wraps from 59:59.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, RUN, PAUSE, LAP.
REQ-015 Transitions on start_stop SHALL be: IDLE->RUN, RUN->PAUSE, PAUSE->RUN, LAP->PAUSE.
- LAP->PAUSE SHALL return the display to the live value.
REQ-016 Transitions on lap SHALL be:
- RUN->LAP, latching the live count into the lap register in the same edge;
- LAP->RUN, display returns to live;
- lap in IDLE or PAUSE is ignored.
REQ-017 clear SHALL, from any state, give next state IDLE, with live count, lap register, prescaler and overflow all zeroed.
REQ-018 Command priority within one cycle SHALL be clear > start_stop > lap; a lower-priority command in that cycle is dropped.
REQ-019 The prescaler SHALL behave as follows:
- counts 0..PRESCALE-1 in RUN and LAP;
- holds its value in PAUSE;
- is 0 in IDLE.
REQ-020 A count increment SHALL occur on the edge where the prescaler equals PRESCALE-1; that same edge returns the prescaler to 0.
REQ-021 The first increment after IDLE->RUN SHALL occur PRESCALE edges after the start_stop edge.
REQ-022 Resuming from PAUSE SHALL continue from the held prescaler value; no phase is lost or restarted.
REQ-023 Digit arithmetic SHALL be:
- sec_ones wraps 9->0 and carries into sec_tens;
- sec_tens wraps 5->0 and carries into min_ones;
- min_ones wraps 9->0 and carries into min_tens;
- min_tens wraps 5->0.
REQ-024 An increment at 59:59 SHALL produce 00:00 and set overflow; counting continues, and overflow stays 1 until clear or reset.
REQ-025 The display outputs SHALL show the lap register while in LAP, and the live count otherwise; this is a combinational mux of registered values.
REQ-026 The live count SHALL continue incrementing while in LAP.
REQ-027 No digit SHALL ever hold a non-BCD value (sec/min tens above 5, units above 9).

Reset
REQ-028 On any clk edge with rst low, the block SHALL:
- enter IDLE;
- zero all digits, the lap register, the prescaler and overflow;
- drive running and lap_valid to 0.
REQ-029 While rst is low, all command inputs SHALL be ignored.
REQ-030 A reset asserted mid-count SHALL take effect on the next edge, with no partial increment.

Structure
REQ-031 Shared package stopwatch_pkg SHALL hold:
- the state enum (IDLE, RUN, PAUSE, LAP);
- constant DIGIT_W = 4;
- constants SEC_TENS_MAX = 5, UNITS_MAX = 9.
REQ-032 One sub-module bcd_mod60 SHALL be used, instantiated twice (seconds pair and minutes pair), with:
- inputs clk, rst, en;
- outputs ones, tens, and a combinational carry = en and ones==9 and tens==5.
REQ-033 stopwatch_ctrl SHALL contain the FSM, the prescaler, the lap register, the overflow flag and the display mux.

Verification (PRESCALE=4)
REQ-034 Hold rst low for 2 edges -> all digits 0, running=0, lap_valid=0, overflow=0.
REQ-035 start_stop pulse, then 40 edges -> display 00:10, running=1; the first change to 00:01 occurs exactly 4 edges after the pulse.
REQ-036 Run to 00:06 plus 2 prescaler counts; pulse start_stop; wait 20 edges -> display stays 00:06; pulse start_stop -> 00:07 appears 2 edges later.
REQ-037 In RUN at 00:05, pulse lap; wait 12 edges:
- display shows 00:05 and lap_valid=1;
- a second lap pulse then shows 00:08 and lap_valid=0.
REQ-038 Run 3600 increments (14400 edges) from 00:00 -> display 00:00, overflow=1; pulse clear -> overflow=0 and the state is IDLE.
REQ-039 In RUN at 12:34, assert clear and start_stop in the same cycle -> next cycle IDLE, display 00:00, running=0.
